// File: rtl/nn_seq_pkg.sv
// Shared types, default constants and helpers for the layer sequencer.
package nn_seq_pkg;

  localparam int DEF_W    = 8;
  localparam int DEF_FRAC = 4;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    MAC,
    BFETCH,
    BADD,
    ACT,
    WRITE,
    DONE
  } state_t;

  // Address width for a memory of n entries; a single entry still gets one bit.
  function automatic int addr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Clamp a wide signed value into the range of a w-bit signed number.
  function automatic logic signed [63:0] saturate(input logic signed [63:0] v, input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/nn_layer_sequencer_if.sv
// Memory, activation and result signals between the sequencer and its environment.
interface nn_layer_sequencer_if
  import nn_seq_pkg::*;
#(
  parameter int N_IN  = 2,
  parameter int N_OUT = 2,
  parameter int W     = DEF_W
);

  localparam int XA_W = addr_w(N_IN);
  localparam int WA_W = addr_w(N_IN * N_OUT);
  localparam int YA_W = addr_w(N_OUT);

  logic                   start;
  logic                   busy;
  logic                   done;
  logic [XA_W-1:0]        x_addr;
  logic signed [W-1:0]    x_data;
  logic [WA_W-1:0]        w_addr;
  logic signed [W-1:0]    w_data;
  logic [YA_W-1:0]        b_addr;
  logic signed [W-1:0]    b_data;
  logic                   act_req;
  logic signed [W-1:0]    act_z;
  logic                   act_ack;
  logic signed [W-1:0]    act_a;
  logic                   y_we;
  logic [YA_W-1:0]        y_addr;
  logic signed [W-1:0]    y_data;

  modport master (
    input  start, x_data, w_data, b_data, act_ack, act_a,
    output busy, done, x_addr, w_addr, b_addr, act_req, act_z, y_we, y_addr, y_data
  );

  modport slave (
    output start, x_data, w_data, b_data, act_ack, act_a,
    input  busy, done, x_addr, w_addr, b_addr, act_req, act_z, y_we, y_addr, y_data
  );

endinterface

// File: rtl/nn_mac_unit.sv
// Multiply-shift-accumulate datapath with bias add and saturation to W bits.
module nn_mac_unit
  import nn_seq_pkg::*;
#(
  parameter int N_IN = 2,
  parameter int W    = DEF_W,
  parameter int FRAC = DEF_FRAC
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clear,
  input  logic                mac_en,
  input  logic                bias_en,
  input  logic signed [W-1:0] x,
  input  logic signed [W-1:0] w,
  input  logic signed [W-1:0] b,
  output logic signed [W-1:0] z
);

  // Wide enough that N_IN full-scale terms plus a bias never wrap.
  localparam int ACC_W = 2 * W + $clog2(N_IN) + 1;

  logic signed [ACC_W-1:0] acc;
  logic signed [2*W-1:0]   prod;
  logic signed [2*W-1:0]   term;
  logic signed [63:0]      biased;

  // Full-precision product, floor-rescaled back to the Q format, and the biased sum.
  always_comb begin
    prod   = (2*W)'(x) * (2*W)'(w);
    term   = prod >>> FRAC;
    biased = 64'(acc) + 64'(b);
  end

  // Accumulator and the saturated pre-activation register.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
      z   <= '0;
    end else begin
      if (clear)       acc <= '0;
      else if (mac_en) acc <= acc + ACC_W'(term);
      if (bias_en)     z <= W'(saturate(biased, W));
    end
  end

endmodule

// File: rtl/nn_layer_sequencer.sv
// Walks every neuron of one dense layer: MAC over the inputs, add bias,
// hand off to an external activation unit and write the result.
module nn_layer_sequencer
  import nn_seq_pkg::*;
#(
  parameter int N_IN  = 2,
  parameter int N_OUT = 2,
  parameter int W     = DEF_W,
  parameter int FRAC  = DEF_FRAC
) (
  input  logic                  clk,
  input  logic                  rst,
  nn_layer_sequencer_if.master  bus
);

  localparam int XA_W = addr_w(N_IN);
  localparam int WA_W = addr_w(N_IN * N_OUT);
  localparam int YA_W = addr_w(N_OUT);
  localparam logic [XA_W-1:0] I_LAST = XA_W'(N_IN - 1);
  localparam logic [YA_W-1:0] J_LAST = YA_W'(N_OUT - 1);

  state_t state, state_next;

  logic [XA_W-1:0]     i;
  logic [YA_W-1:0]     j;
  logic [XA_W-1:0]     x_addr_q;
  logic [WA_W-1:0]     w_addr_q;
  logic [WA_W-1:0]     w_addr_cur;
  logic [YA_W-1:0]     b_addr_q;
  logic [YA_W-1:0]     y_addr_q;
  logic signed [W-1:0] y_data_q;
  logic signed [W-1:0] act_z_w;
  logic                mac_clear;
  logic                mac_en;
  logic                bias_en;

  assign w_addr_cur = WA_W'(j) * WA_W'(N_IN) + WA_W'(i);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic and datapath control strobes.
  always_comb begin
    state_next = state;
    mac_clear  = 1'b0;
    mac_en     = 1'b0;
    bias_en    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_next = FETCH;
          mac_clear  = 1'b1;
        end
      end
      FETCH:  state_next = MAC;
      MAC: begin
        mac_en     = 1'b1;
        state_next = (i == I_LAST) ? BFETCH : FETCH;
      end
      BFETCH: state_next = BADD;
      BADD: begin
        bias_en    = 1'b1;
        state_next = ACT;
      end
      ACT: begin
        if (bus.act_ack) state_next = WRITE;
      end
      WRITE: begin
        if (j == J_LAST) begin
          state_next = DONE;
        end else begin
          state_next = FETCH;
          mac_clear  = 1'b1;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Input/neuron counters, held copies of the addresses and the captured activation.
  always_ff @(posedge clk) begin
    if (rst) begin
      i        <= '0;
      j        <= '0;
      x_addr_q <= '0;
      w_addr_q <= '0;
      b_addr_q <= '0;
      y_addr_q <= '0;
      y_data_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            i <= '0;
            j <= '0;
          end
        end
        FETCH: begin
          x_addr_q <= i;
          w_addr_q <= w_addr_cur;
        end
        MAC: begin
          if (i != I_LAST) i <= i + XA_W'(1);
        end
        BFETCH: b_addr_q <= j;
        ACT: begin
          if (bus.act_ack) y_data_q <= bus.act_a;
        end
        WRITE: begin
          y_addr_q <= j;
          if (j != J_LAST) begin
            j <= j + YA_W'(1);
            i <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  nn_mac_unit #(
    .N_IN (N_IN),
    .W    (W),
    .FRAC (FRAC)
  ) u_mac (
    .clk     (clk),
    .rst     (rst),
    .clear   (mac_clear),
    .mac_en  (mac_en),
    .bias_en (bias_en),
    .x       (bus.x_data),
    .w       (bus.w_data),
    .b       (bus.b_data),
    .z       (act_z_w)
  );

  assign bus.busy    = (state != IDLE);
  assign bus.done    = (state == DONE);
  assign bus.act_req = (state == ACT);
  assign bus.y_we    = (state == WRITE);
  assign bus.x_addr  = (state == FETCH)  ? i          : x_addr_q;
  assign bus.w_addr  = (state == FETCH)  ? w_addr_cur : w_addr_q;
  assign bus.b_addr  = (state == BFETCH) ? j          : b_addr_q;
  assign bus.y_addr  = (state == WRITE)  ? j          : y_addr_q;
  assign bus.y_data  = y_data_q;
  assign bus.act_z   = act_z_w;

endmodule

// File: tb/tb_nn_layer_sequencer.sv
// Self-checking bench: a single-neuron instance driven from a vector table and
// a two-neuron instance for activation handshake, start filtering and reset abort.
module tb_nn_layer_sequencer;

  typedef struct {
    int x0;
    int x1;
    int w0;
    int w1;
    int b;
    int z;
  } vec_t;

  typedef struct {
    int addr;
    int z;
    int y;
  } exp_t;

  localparam int NV = 10;

  logic clk = 1'b0;
  logic rstA;
  logic rstB;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;

  nn_layer_sequencer_if #(.N_IN(2), .N_OUT(1), .W(8)) busA ();
  nn_layer_sequencer_if #(.N_IN(2), .N_OUT(2), .W(8)) busB ();

  nn_layer_sequencer #(.N_IN(2), .N_OUT(1), .W(8), .FRAC(4)) dutA (
    .clk (clk),
    .rst (rstA),
    .bus (busA)
  );

  nn_layer_sequencer #(.N_IN(2), .N_OUT(2), .W(8), .FRAC(4)) dutB (
    .clk (clk),
    .rst (rstB),
    .bus (busB)
  );

  logic signed [7:0] xA [2];
  logic signed [7:0] wA [2];
  logic signed [7:0] bA [2];
  logic signed [7:0] xB [2];
  logic signed [7:0] wB [4];
  logic signed [7:0] bB [2];

  exp_t qA [$];
  exp_t qB [$];
  vec_t vecs [NV];

  int   ackDelayA = 1;
  int   ackDelayB = 3;
  int   ackCntA = 0;
  int   ackCntB = 0;
  logic strayB = 1'b0;

  int startCycA = 0;
  int startCycB = 0;
  int reqCntA = 0;
  int reqCntB = 0;
  int lastWeRelA = -1;
  int lastDoneRelA = -1;
  int lastWeRelB = -1;
  int lastDoneRelB = -1;
  int weCntB = 0;
  int doneCntB = 0;

  // Free-running clock and cycle counter.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous-read memories: data appears the cycle after the address.
  always @(posedge clk) begin
    busA.x_data <= xA[busA.x_addr];
    busA.w_data <= wA[busA.w_addr];
    busA.b_data <= bA[busA.b_addr];
    busB.x_data <= xB[busB.x_addr];
    busB.w_data <= wB[busB.w_addr];
    busB.b_data <= bB[busB.b_addr];
  end

  // Activation responders: count request cycles and acknowledge after the configured delay.
  always @(posedge clk) begin
    ackCntA <= busA.act_req ? ackCntA + 1 : 0;
    ackCntB <= busB.act_req ? ackCntB + 1 : 0;
  end

  assign busA.act_ack = busA.act_req && (ackCntA == ackDelayA - 1);
  assign busA.act_a   = busA.act_z;
  assign busB.act_ack = busB.act_req ? (ackCntB == ackDelayB - 1) : strayB;
  assign busB.act_a   = ~busB.act_z;

  task automatic checkOutput(input string name, input logic signed [31:0] actual,
                             input logic signed [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  function automatic int modelZ(input int x0, input int x1, input int w0, input int w1, input int b);
    int acc;
    acc = ((x0 * w0) >>> 4) + ((x1 * w1) >>> 4) + b;
    if (acc > 127)  acc = 127;
    if (acc < -128) acc = -128;
    return acc;
  endfunction

  function automatic int invW(input int z);
    logic signed [7:0] t;
    t = 8'(z);
    t = ~t;
    return int'(t);
  endfunction

  // Scoreboard for the single-neuron instance, sampled away from the active edge.
  always @(negedge clk) begin
    if (rstA) begin
      reqCntA = 0;
    end else begin
      if (busA.act_req) begin
        reqCntA++;
        checkOutput("A_act_req_expected", int'(qA.size() > 0), 1);
        if (qA.size() > 0) checkOutput("A_act_z", busA.act_z, qA[0].z);
      end else if (reqCntA != 0) begin
        checkOutput("A_act_req_cycles", reqCntA, ackDelayA);
        reqCntA = 0;
      end
      if (busA.y_we) begin
        lastWeRelA = cyc - startCycA;
        checkOutput("A_y_we_expected", int'(qA.size() > 0), 1);
        if (qA.size() > 0) begin
          exp_t e;
          e = qA.pop_front();
          checkOutput("A_y_addr", busA.y_addr, e.addr);
          checkOutput("A_y_data", busA.y_data, e.y);
        end
      end
      if (busA.done) lastDoneRelA = cyc - startCycA;
    end
  end

  // Scoreboard for the two-neuron instance; strobes are counted even during reset.
  always @(negedge clk) begin
    if (busB.y_we) weCntB++;
    if (busB.done) doneCntB++;
    if (rstB) begin
      reqCntB = 0;
    end else begin
      if (busB.act_req) begin
        reqCntB++;
        checkOutput("B_act_req_expected", int'(qB.size() > 0), 1);
        if (qB.size() > 0) checkOutput("B_act_z", busB.act_z, qB[0].z);
      end else if (reqCntB != 0) begin
        checkOutput("B_act_req_cycles", reqCntB, ackDelayB);
        reqCntB = 0;
      end
      if (busB.y_we) begin
        lastWeRelB = cyc - startCycB;
        checkOutput("B_y_we_expected", int'(qB.size() > 0), 1);
        if (qB.size() > 0) begin
          exp_t e;
          e = qB.pop_front();
          checkOutput("B_y_addr", busB.y_addr, e.addr);
          checkOutput("B_y_data", busB.y_data, e.y);
        end
      end
      if (busB.done) lastDoneRelB = cyc - startCycB;
    end
  end

  task automatic applyStimulus(input vec_t v);
    int n;
    xA[0] = 8'(v.x0);
    xA[1] = 8'(v.x1);
    wA[0] = 8'(v.w0);
    wA[1] = 8'(v.w1);
    bA[0] = 8'(v.b);
    qA.push_back('{addr: 0, z: v.z, y: v.z});
    lastWeRelA   = -1;
    lastDoneRelA = -1;
    @(posedge clk); #1;
    busA.start = 1'b1;
    startCycA  = cyc;
    @(posedge clk); #1;
    busA.start = 1'b0;
    n = 0;
    while (!busA.done && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("A_done_seen", busA.done, 1);
    @(posedge clk); #1;
    checkOutput("A_y_we_cycle", lastWeRelA, 8);
    checkOutput("A_done_cycle", lastDoneRelA, 9);
    checkOutput("A_queue_left", qA.size(), 0);
    checkOutput("A_busy_after", busA.busy, 0);
  endtask

  task automatic pushB();
    for (int jj = 0; jj < 2; jj++) begin
      int z;
      z = modelZ(xB[0], xB[1], wB[2*jj], wB[2*jj+1], bB[jj]);
      qB.push_back('{addr: jj, z: z, y: invW(z)});
    end
  endtask

  task automatic runB(input string tag);
    int n;
    pushB();
    lastWeRelB   = -1;
    lastDoneRelB = -1;
    @(posedge clk); #1;
    busB.start = 1'b1;
    startCycB  = cyc;
    @(posedge clk); #1;
    busB.start = 1'b0;
    n = 0;
    while (!busB.done && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput({tag, "_done_seen"}, busB.done, 1);
    @(posedge clk); #1;
    checkOutput({tag, "_y_we_cycle"}, lastWeRelB, 20);
    checkOutput({tag, "_done_cycle"}, lastDoneRelB, 21);
    checkOutput({tag, "_queue_left"}, qB.size(), 0);
  endtask

  // Hard stop in case something never returns to idle.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main test sequence.
  initial begin
    int n;
    int weBefore;
    int doneBefore;

    vecs[0] = '{16, 16, -23, 23, -9, -9};
    vecs[1] = '{127, 127, 127, 127, 127, 127};
    vecs[2] = '{-128, -128, 127, 127, -128, -128};
    vecs[3] = '{1, 0, -1, 0, 0, -1};
    vecs[4] = '{32, -16, 8, 8, 5, 13};
    vecs[5] = '{3, 5, 7, -2, 0, 0};
    vecs[6] = '{-1, -1, -1, -1, 100, 100};
    vecs[7] = '{100, 100, 100, -100, 20, 20};
    vecs[8] = '{0, 0, 0, 0, -128, -128};
    vecs[9] = '{-128, -128, -128, -128, 0, 127};

    for (int k = 0; k < 2; k++) begin
      xA[k] = '0; wA[k] = '0; bA[k] = '0;
      xB[k] = '0; bB[k] = '0;
    end
    for (int k = 0; k < 4; k++) wB[k] = '0;

    rstA = 1'b1;
    rstB = 1'b1;
    busA.start = 1'b0;
    busB.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    checkOutput("rst_busy", busA.busy, 0);
    checkOutput("rst_done", busA.done, 0);
    checkOutput("rst_act_req", busA.act_req, 0);
    checkOutput("rst_y_we", busA.y_we, 0);
    checkOutput("rst_act_z", busA.act_z, 0);
    checkOutput("rst_y_data", busA.y_data, 0);
    checkOutput("rst_x_addr", busA.x_addr, 0);
    checkOutput("rst_w_addr", busA.w_addr, 0);
    checkOutput("rst_b_addr", busA.b_addr, 0);
    checkOutput("rst_y_addr", busA.y_addr, 0);
    checkOutput("rst_B_busy", busB.busy, 0);
    checkOutput("rst_B_act_z", busB.act_z, 0);

    rstA = 1'b0;
    rstB = 1'b0;

    for (int k = 0; k < NV; k++) applyStimulus(vecs[k]);

    xB[0] = 8'sd16;  xB[1] = 8'sd32;
    wB[0] = 8'sd16;  wB[1] = 8'sd16;
    wB[2] = -8'sd16; wB[3] = 8'sd8;
    bB[0] = 8'sd1;   bB[1] = -8'sd2;
    runB("B_slow_ack");

    weCntB   = 0;
    doneCntB = 0;
    pushB();
    strayB = 1'b1;
    @(posedge clk); #1;
    busB.start = 1'b1;
    startCycB  = cyc;
    n = 0;
    while (1) begin
      @(posedge clk); #1;
      n++;
      if (!busB.busy || n > 200) break;
      busB.start = busB.done ? 1'b1 : ((n % 2) == 1);
    end
    busB.start = 1'b0;
    strayB = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    checkOutput("B_start_spam_finished", int'(n <= 200), 1);
    checkOutput("B_start_spam_y_we", weCntB, 2);
    checkOutput("B_start_spam_done", doneCntB, 1);
    checkOutput("B_start_spam_idle", busB.busy, 0);
    checkOutput("B_start_spam_queue", qB.size(), 0);

    pushB();
    @(posedge clk); #1;
    busB.start = 1'b1;
    startCycB  = cyc;
    @(posedge clk); #1;
    busB.start = 1'b0;
    n = 0;
    while (!busB.act_req && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("B_reached_act", busB.act_req, 1);
    weBefore   = weCntB;
    doneBefore = doneCntB;
    rstB = 1'b1;
    @(posedge clk); #1;
    checkOutput("B_abort_busy", busB.busy, 0);
    checkOutput("B_abort_act_req", busB.act_req, 0);
    checkOutput("B_abort_y_we", busB.y_we, 0);
    checkOutput("B_abort_done", busB.done, 0);
    checkOutput("B_abort_act_z", busB.act_z, 0);
    rstB = 1'b0;
    qB.delete();
    repeat (5) @(posedge clk);
    #1;
    checkOutput("B_abort_no_y_we", weCntB, weBefore);
    checkOutput("B_abort_no_done", doneCntB, doneBefore);

    bB[0] = 8'sd5;
    bB[1] = 8'sd5;
    runB("B_after_abort");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/nn_layer_sequencer.md
NN_LAYER_SEQUENCER -- requirements
Module: nn_layer_sequencer

Interface
REQ-001 Parameter N_IN, default 2, inputs per neuron (1..16).
REQ-002 Parameter N_OUT, default 2, neurons per layer (1..16).
REQ-003 Parameter W, default 8, signed data/weight/bias width.
REQ-004 Parameter FRAC, default 4, fractional bits (Q(W-FRAC).FRAC).
REQ-005 clk  in  1  clock; all logic on posedge clk.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 start  in  1  begin one layer evaluation; sampled only in IDLE.
REQ-008 busy  out  1  high in every state except IDLE.
REQ-009 done  out  1  one-cycle pulse at end of layer.
REQ-010 x_addr  out  clog2(N_IN)  input-vector read address; x_data valid the cycle after.
REQ-011 x_data  in  W  signed input value.
REQ-012 w_addr  out  clog2(N_IN*N_OUT)  weight address = j*N_IN+i; w_data valid the cycle after.
REQ-013 w_data  in  W  signed weight.
REQ-014 b_addr  out  clog2(N_OUT)  bias address = j; b_data valid the cycle after.
REQ-015 b_data  in  W  signed bias.
REQ-016 act_req  out  1  activation request; act_z stable while high.
REQ-017 act_z  out  W  saturated pre-activation value.
REQ-018 act_ack  in  1  activation result valid on act_a.
REQ-019 act_a  in  W  activation result.
REQ-020 y_we / y_addr / y_data  out  1 / clog2(N_OUT) / W  result write strobe, neuron index, value.

Function
REQ-021 FSM states: IDLE, FETCH, MAC, BFETCH, BADD, ACT, WRITE, DONE.
REQ-022 IDLE: start=1 -> FETCH with i=0, j=0, accumulator cleared; otherwise stay.
REQ-023 FETCH: drive x_addr=i and w_addr=j*N_IN+i for one cycle -> MAC.
REQ-024 MAC: acc += (x_data*w_data) >>> FRAC (full 2W product, arithmetic shift, floor); i<N_IN-1 -> i++, FETCH; else -> BFETCH.
REQ-025 Accumulator width 2W+clog2(N_IN)+1; no wrap inside accumulation.
REQ-026 BFETCH: drive b_addr=j -> BADD.
REQ-027 BADD: act_z <= saturate_W(acc + sign-extended b_data), clamped to [-2^(W-1), 2^(W-1)-1] -> ACT.
REQ-028 ACT: act_req=1 every cycle in ACT; on act_ack=1 capture act_a, drop act_req the next cycle -> WRITE; act_ack outside ACT ignored.
REQ-029 WRITE: y_we=1 for exactly one cycle with y_addr=j, y_data=captured act_a; j<N_OUT-1 -> j++, i=0, acc=0, FETCH; else -> DONE.
REQ-030 DONE: done=1 one cycle -> IDLE.
REQ-031 start while busy ignored; start in DONE cycle ignored.
REQ-032 Latency: start at cycle 0, done at cycle N_OUT*(2*N_IN+3+k)+1, k = ACT cycles per neuron (k>=1).
REQ-033 Address outputs hold last value outside their issuing state; only y_we/act_req/done are strobes.

Reset
REQ-034 rst has priority over all inputs, including start and act_ack.
REQ-035 On rst: state=IDLE, i=j=0, acc=0, busy=done=act_req=y_we=0, act_z=y_data=0, all addresses 0.
REQ-036 rst mid-operation (any state, incl. ACT with act_req high) aborts the layer; no y_we or done is issued; next start restarts at neuron 0.

Structure
REQ-037 Package nn_seq_pkg holds the state enum, default W/FRAC constants and the saturate function.
REQ-038 One sub-module nn_mac_unit: clear/enable multiply-shift-accumulate with bias add and saturation; FSM and counters stay in nn_layer_sequencer.

Verification
REQ-039 N_IN=2,N_OUT=1, x={16,16}, w={-23,23}, b=-9, act_a=act_z echo with ack in first ACT cycle -> act_z=-9, y_we at cycle 8 with y_data=-9, y_addr=0, done at cycle 9.
REQ-040 x={127,127}, w={127,127}, b=127 -> act_z=127 (positive saturation); x={-128,-128}, w={127,127}, b=-128 -> act_z=-128.
REQ-041 x={1,0}, w={-1,0}, b=0 -> product term -1 (floor), act_z=-1.
REQ-042 N_OUT=2, act_ack delayed 3 cycles per neuron -> act_req high 3 cycles each, act_z stable, y_addr 0 then 1, done at cycle 2*(7+3)+1=21.
REQ-043 start pulsed repeatedly while busy -> single evaluation, exactly N_OUT y_we pulses, one done.
REQ-044 rst asserted in ACT with act_req high -> next cycle IDLE, act_req=0, busy=0, no y_we/done; subsequent start produces correct results from neuron 0.
